// File: rtl/opb_register_bank_ppc2simulink_if.sv
// ----------------------------------------------------------------------------
// opb_register_bank_ppc2simulink_if
//
// OPB slave-side bus bundle for the PPC-to-Simulink register bank.
// Vectors keep the OPB big-endian numbering: bit 0 is the MSB.
//
// Signals
//   OPB_ABus    [0:31]  address from the bus master
//   OPB_BE      [0:3]   byte enables (BE[0] covers DBus[0:7])
//   OPB_DBus    [0:31]  write data
//   OPB_RNW             1 = read, 0 = write
//   OPB_select          master select
//   OPB_seqAddr         sequential-address hint
//   Sl_DBus     [0:31]  slave read data
//   Sl_xferAck          slave transfer acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup  slave status lines
//
// Modports
//   master : drives the OPB_* lines, observes the Sl_* lines
//   slave  : observes the OPB_* lines, drives the Sl_* lines
// ----------------------------------------------------------------------------
interface opb_register_bank_ppc2simulink_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;

  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// ----------------------------------------------------------------------------
// opb_register_bank_ppc2simulink
//
// OPB slave holding N_REGS 32-bit read/write control registers in one address
// window, for handing software-written values to Simulink-generated DSP logic.
// Each register has a one-cycle load strobe, and registers selected by
// SELFCLR_MASK return to zero one cycle after their strobe (command-style
// registers). Everything runs on OPB_Clk.
//
// Ports
//   OPB_Clk        sole clock, rising edge
//   OPB_Rst        asynchronous, active-high reset
//   opb            OPB slave bus bundle (see opb_register_bank_ppc2simulink_if)
//   user_data_out  register i on bits [32*i+31:32*i]
//   user_load      one-cycle pulse per register on each committed write
//
// Transfer timing (hit sampled in cycle t):
//   t+1  Sl_xferAck high, Sl_DBus carries the register value from cycle t
//   t+2  written value visible on user_data_out, user_load[idx] high
//   t+3  self-clearing registers read zero again
// ----------------------------------------------------------------------------
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]        C_BASEADDR   = 32'h01108500,
  parameter logic [31:0]        C_HIGHADDR   = 32'h011085FF,
  parameter int                 C_OPB_AWIDTH = 32,
  parameter int                 C_OPB_DWIDTH = 32,
  parameter int                 N_REGS       = 4,
  parameter logic [N_REGS-1:0]  SELFCLR_MASK = '0,
  parameter string              C_FAMILY     = "virtex6"
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave opb,
  output logic [N_REGS*32-1:0]         user_data_out,
  output logic [N_REGS-1:0]            user_load
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state;
  logic             ack;
  logic [31:0]      rd_data_q;
  logic             rnw_q;
  logic [3:0]       be_q;
  logic [31:0]      data_q;
  logic [IDX_W-1:0] idx_q;
  logic             mapped_q;

  logic [31:0]      regs [N_REGS];

  logic [31:0]      addr;
  logic [31:0]      offset;
  logic             hit;
  logic             mapped;
  logic [IDX_W-1:0] idx_hit;
  logic [31:0]      rd_value;
  logic             write_fire;
  logic             unused_ok;

  // Address decode. Assigning the [0:31] bus straight into a [31:0] vector
  // keeps OPB bit 0 as the MSB, which is exactly the register bit order.
  assign addr    = opb.OPB_ABus;
  assign offset  = addr - C_BASEADDR;
  assign hit     = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign mapped  = ({2'b00, offset[31:2]} < 32'(N_REGS));
  assign idx_hit = offset[IDX_W+1:2];

  // The sequential-address hint and byte-offset bits carry no meaning here.
  assign unused_ok = &{1'b0, opb.OPB_seqAddr, offset[1:0]};

  // Read mux; unmapped slots inside the window read as zero.
  always_comb begin
    rd_value = '0;
    if (mapped) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (idx_hit == IDX_W'(i)) begin
          rd_value = regs[i];
        end
      end
    end
  end

  // Transfer FSM. The GAP state keeps a still-asserted select from being
  // acked a second time; the request fields are captured on the hit cycle.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state     <= ST_IDLE;
      ack       <= 1'b0;
      rd_data_q <= '0;
      rnw_q     <= 1'b1;
      be_q      <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      mapped_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hit) begin
            state     <= ST_ACK;
            ack       <= 1'b1;
            rnw_q     <= opb.OPB_RNW;
            be_q      <= opb.OPB_BE;
            data_q    <= opb.OPB_DBus;
            idx_q     <= idx_hit;
            mapped_q  <= mapped;
            rd_data_q <= opb.OPB_RNW ? rd_value : 32'h0;
          end
        end
        ST_ACK: begin
          state     <= ST_GAP;
          ack       <= 1'b0;
          rd_data_q <= '0;
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          ack       <= 1'b0;
          rd_data_q <= '0;
        end
      endcase
    end
  end

  // A captured write commits at the end of the ACK cycle, even if the master
  // has already dropped select.
  assign write_fire = (state == ST_ACK) && !rnw_q && mapped_q;

  // Register file and load strobes. be_q[3] is OPB BE[0], i.e. bits 31:24.
  // A commit takes priority over a pending self-clear of the same register.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
      user_load <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) begin
        if (write_fire && (idx_q == IDX_W'(i))) begin
          for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
              regs[i][8*b +: 8] <= data_q[8*b +: 8];
            end
          end
          user_load[i] <= 1'b1;
        end else begin
          if (SELFCLR_MASK[i] && user_load[i]) begin
            regs[i] <= '0;
          end
          user_load[i] <= 1'b0;
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = regs[g];
    end
  endgenerate

  assign opb.Sl_DBus    = ack ? rd_data_q : 32'h0;
  assign opb.Sl_xferAck = ack;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule
